// File: rtl/dsky_relay_decoder.sv
// ---------------------------------------------------------------------------
// dsky_relay_decoder
//
// Consumes the AGC relay-word bus (RLYB01..11 data, RYWD12/13/14/16 row code)
// and maintains a 12-row DSKY relay image. The bus is asynchronous, so it is
// first synchronised. A word is committed only after it has been seen unchanged
// for STABLE_CYCLES consecutive sample comparisons. This filters the glitches
// that appear between AGC output register updates.
//
// Ports
//   SIM_CLK      in   1   single clock for all logic
//   SIM_RST      in   1   synchronous, active-high reset
//   rlyb         in   11  relay data {RLYB11..RLYB01}, asynchronous
//   rywd         in   4   row code {RYWD16,RYWD14,RYWD13,RYWD12}, asynchronous
//   wr_stb       out  1   one-cycle pulse: image row updated this cycle
//   wr_row       out  4   committed row (1..12), held between commits
//   wr_data      out  11  committed data, held between commits
//   rd_row       in   4   image read address
//   rd_data      out  11  image[rd_row] one cycle later; 0 for rows 0,13..15
//   bad_row_cnt  out  8   saturating count of stable words with row 13..15
//   dbg_state    out  2   current FSM state (IDLE=0 SETTLE=1 ACCEPT=2 DONE=3)
//
// Handshake: there is no flow control. wr_stb qualifies wr_row/wr_data for
// exactly one cycle and cannot be back-pressured. rd_row is always accepted,
// and rd_data answers it one cycle later.
// ---------------------------------------------------------------------------
module dsky_relay_decoder #(
  parameter int STABLE_CYCLES = 256,
  parameter int CNT_W         = 9
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic [10:0] rlyb,
  input  logic [3:0]  rywd,
  output logic        wr_stb,
  output logic [3:0]  wr_row,
  output logic [10:0] wr_data,
  input  logic [3:0]  rd_row,
  output logic [10:0] rd_data,
  output logic [7:0]  bad_row_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCEPT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Two-flop synchronisers; the second stage is the working sample s.
  logic [10:0] data_meta, s_data;
  logic [3:0]  row_meta, s_row;

  // p holds the previous sample that s is compared against.
  logic [14:0] p;
  logic [14:0] s;

  logic [CNT_W-1:0] cnt, cnt_n;
  state_t           state, state_n;
  logic             load_p;
  logic             commit;
  logic             same;

  // Row image. Rows 0 and 13..15 are never written and stay 0, which also
  // makes them read back as 0 without extra masking.
  logic [10:0] image [16];

  assign s         = {s_row, s_data};
  assign same      = (s == p);
  assign dbg_state = state;

  // Next-state logic. The counter loads 1 when a new word is captured into p.
  // It then advances once per equal comparison and stops at CNT_MAX. When it
  // is at CNT_MAX and s still equals p, the FSM arms (ACCEPT). The word
  // commits on the following equal comparison. A word therefore needs
  // STABLE_CYCLES consecutive equal comparisons after its capture.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load_p  = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (s_row != 4'd0) begin
          state_n = SETTLE;
          cnt_n   = CNT_ONE;
          load_p  = 1'b1;
        end
      end
      SETTLE, ACCEPT: begin
        if (!same) begin
          load_p = 1'b1;
          if (s_row == 4'd0) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n = SETTLE;
            cnt_n   = CNT_ONE;
          end
        end else if (state == ACCEPT) begin
          commit  = 1'b1;
          state_n = DONE;
        end else if (cnt == CNT_MAX) begin
          state_n = ACCEPT;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      DONE: begin
        // Word already committed; only a change re-arms settling.
        if (!same) begin
          load_p = 1'b1;
          if (s_row == 4'd0) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n = SETTLE;
            cnt_n   = CNT_ONE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      data_meta   <= '0;
      row_meta    <= '0;
      s_data      <= '0;
      s_row       <= '0;
      p           <= '0;
      cnt         <= '0;
      state       <= IDLE;
      wr_stb      <= 1'b0;
      wr_row      <= '0;
      wr_data     <= '0;
      rd_data     <= '0;
      bad_row_cnt <= '0;
      for (int i = 0; i < 16; i++) begin
        image[i] <= '0;
      end
    end else begin
      data_meta <= rlyb;
      row_meta  <= rywd;
      s_data    <= data_meta;
      s_row     <= row_meta;
      state     <= state_n;
      cnt       <= cnt_n;
      wr_stb    <= 1'b0;
      if (load_p) begin
        p <= s;
      end
      // Registered read samples the image before this edge's write lands,
      // so a same-cycle read returns the old row value.
      rd_data <= image[rd_row];
      if (commit) begin
        if (s_row <= 4'd12) begin
          image[s_row] <= s_data;
          wr_stb       <= 1'b1;
          wr_row       <= s_row;
          wr_data      <= s_data;
        end else if (bad_row_cnt != 8'hFF) begin
          bad_row_cnt <= bad_row_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsky_relay_decoder.sv
module tb_dsky_relay_decoder;

  logic        SIM_CLK;
  logic        SIM_RST;
  logic [10:0] rlyb;
  logic [3:0]  rywd;
  logic        wr_stb;
  logic [3:0]  wr_row;
  logic [10:0] wr_data;
  logic [3:0]  rd_row;
  logic [10:0] rd_data;
  logic [7:0]  bad_row_cnt;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // Clock / reset
  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  dsky_relay_decoder #(.STABLE_CYCLES(256), .CNT_W(9)) dut (
    .SIM_CLK    (SIM_CLK),
    .SIM_RST    (SIM_RST),
    .rlyb       (rlyb),
    .rywd       (rywd),
    .wr_stb     (wr_stb),
    .wr_row     (wr_row),
    .wr_data    (wr_data),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .bad_row_cnt(bad_row_cnt),
    .dbg_state  (dbg_state)
  );

  // Strobe monitor: counts posedges, logs every wr_stb pulse just after the edge.
  int          cyc = 0;
  int          stb_count = 0;
  int          stb_cyc = 0;
  logic [14:0] stb_log[$];

  always @(posedge SIM_CLK) begin
    cyc = cyc + 1;
    #1;
    if (wr_stb === 1'b1) begin
      stb_count = stb_count + 1;
      stb_cyc   = cyc;
      stb_log.push_back({wr_row, wr_data});
    end
  end

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge SIM_CLK);
  endtask

  task automatic drive_bus(input logic [3:0] row, input logic [10:0] data);
    rywd = row;
    rlyb = data;
  endtask

  task automatic test_reset;
    SIM_RST = 1'b1;
    drive_bus(4'd0, 11'd0);
    rd_row = 4'd0;
    wait_cyc(3);
    total++; if (wr_stb !== 1'b0) begin bad++; $display("FAIL reset_wr_stb got=%0b exp=0", wr_stb); end
    total++; if (wr_row !== 4'd0) begin bad++; $display("FAIL reset_wr_row got=%0d exp=0", wr_row); end
    total++; if (wr_data !== 11'd0) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
    total++; if (rd_data !== 11'd0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    total++; if (bad_row_cnt !== 8'd0) begin bad++; $display("FAIL reset_bad_cnt got=%0d exp=0", bad_row_cnt); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    SIM_RST = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_single_word;
    int c0, n0;
    n0 = stb_count;
    drive_bus(4'd3, 11'h2A5);
    c0 = cyc;
    wait_cyc(300);
    total++; if (stb_count - n0 !== 1) begin bad++; $display("FAIL single_stb_count got=%0d exp=1", stb_count - n0); end
    total++; if (stb_cyc - c0 !== 259) begin bad++; $display("FAIL single_latency got=%0d exp=259", stb_cyc - c0); end
    total++; if (wr_row !== 4'd3) begin bad++; $display("FAIL single_wr_row got=%0d exp=3", wr_row); end
    total++; if (wr_data !== 11'h2A5) begin bad++; $display("FAIL single_wr_data got=%h exp=2a5", wr_data); end
    rd_row = 4'd3;
    wait_cyc(1);
    total++; if (rd_data !== 11'h2A5) begin bad++; $display("FAIL single_rd_data got=%h exp=2a5", rd_data); end
    drive_bus(4'd0, 11'd0);
    wait_cyc(5);
  endtask

  task automatic test_glitch;
    int n0;
    n0 = stb_count;
    for (int i = 0; i < 10; i++) begin
      drive_bus(4'd5, (i % 2 == 0) ? 11'h001 : 11'h002);
      wait_cyc(100);
    end
    total++; if (stb_count !== n0) begin bad++; $display("FAIL glitch_no_stb got=%0d exp=%0d", stb_count, n0); end
    drive_bus(4'd0, 11'd0);
    wait_cyc(5);
    rd_row = 4'd5;
    wait_cyc(1);
    total++; if (rd_data !== 11'd0) begin bad++; $display("FAIL glitch_row5 got=%h exp=0", rd_data); end
  endtask

  task automatic test_bad_rows;
    int n0;
    n0 = stb_count;
    for (int i = 1; i <= 260; i++) begin
      drive_bus(4'hE, 11'h7FF);
      wait_cyc(300);
      drive_bus(4'd0, 11'd0);
      wait_cyc(5);
      if (i == 1) begin
        total++; if (bad_row_cnt !== 8'd1) begin bad++; $display("FAIL bad_cnt_first got=%0d exp=1", bad_row_cnt); end
      end
      if (i == 254) begin
        total++; if (bad_row_cnt !== 8'd254) begin bad++; $display("FAIL bad_cnt_254 got=%0d exp=254", bad_row_cnt); end
      end
    end
    total++; if (bad_row_cnt !== 8'd255) begin bad++; $display("FAIL bad_cnt_sat got=%0d exp=255", bad_row_cnt); end
    total++; if (stb_count !== n0) begin bad++; $display("FAIL bad_no_stb got=%0d exp=%0d", stb_count, n0); end
  endtask

  task automatic test_back_to_back;
    int n0, c1;
    n0 = stb_count;
    rd_row = 4'd7;
    drive_bus(4'd7, 11'h100);
    wait_cyc(300);
    drive_bus(4'd7, 11'h200);
    c1 = cyc;
    wait_cyc(259);
    total++; if (wr_stb !== 1'b1) begin bad++; $display("FAIL b2b_second_stb got=%0b exp=1", wr_stb); end
    total++; if (rd_data !== 11'h100) begin bad++; $display("FAIL b2b_old_read got=%h exp=100", rd_data); end
    wait_cyc(1);
    total++; if (rd_data !== 11'h200) begin bad++; $display("FAIL b2b_new_read got=%h exp=200", rd_data); end
    total++; if (stb_count - n0 !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", stb_count - n0); end
    if (stb_log.size() >= n0 + 2) begin
      total++; if (stb_log[n0] !== {4'd7, 11'h100}) begin bad++; $display("FAIL b2b_first_word got=%h exp=%h", stb_log[n0], {4'd7, 11'h100}); end
      total++; if (stb_log[n0+1] !== {4'd7, 11'h200}) begin bad++; $display("FAIL b2b_second_word got=%h exp=%h", stb_log[n0+1], {4'd7, 11'h200}); end
    end
    total++; if (stb_cyc - c1 !== 259) begin bad++; $display("FAIL b2b_latency got=%0d exp=259", stb_cyc - c1); end
    drive_bus(4'd0, 11'd0);
    wait_cyc(5);
  endtask

  task automatic test_reset_mid_settle;
    int n0, r0;
    drive_bus(4'd2, 11'h055);
    wait_cyc(150);
    SIM_RST = 1'b1;
    wait_cyc(1);
    SIM_RST = 1'b0;
    r0 = cyc;
    n0 = stb_count;
    for (int r = 1; r <= 12; r++) begin
      rd_row = 4'(r);
      wait_cyc(1);
      total++; if (rd_data !== 11'd0) begin bad++; $display("FAIL rst_row%0d got=%h exp=0", r, rd_data); end
    end
    while (cyc < r0 + 258) wait_cyc(1);
    total++; if (stb_count !== n0) begin bad++; $display("FAIL rst_early_stb got=%0d exp=%0d", stb_count, n0); end
    wait_cyc(1);
    total++; if (wr_stb !== 1'b1) begin bad++; $display("FAIL rst_stb_at_259 got=%0b exp=1", wr_stb); end
    total++; if (stb_cyc - r0 !== 259) begin bad++; $display("FAIL rst_latency got=%0d exp=259", stb_cyc - r0); end
    total++; if (wr_data !== 11'h055) begin bad++; $display("FAIL rst_wr_data got=%h exp=055", wr_data); end
    drive_bus(4'd0, 11'd0);
    wait_cyc(5);
  endtask

  task automatic test_row_zero;
    int n0;
    logic [7:0] b0;
    n0 = stb_count;
    b0 = bad_row_cnt;
    for (int i = 0; i < 10; i++) begin
      drive_bus(4'd0, 11'($urandom_range(0, 2047)));
      wait_cyc(100);
    end
    total++; if (stb_count !== n0) begin bad++; $display("FAIL row0_no_stb got=%0d exp=%0d", stb_count, n0); end
    total++; if (bad_row_cnt !== b0) begin bad++; $display("FAIL row0_bad_cnt got=%0d exp=%0d", bad_row_cnt, b0); end
    rd_row = 4'd0;
    wait_cyc(1);
    total++; if (rd_data !== 11'd0) begin bad++; $display("FAIL rd_row0 got=%h exp=0", rd_data); end
    rd_row = 4'd13;
    wait_cyc(1);
    total++; if (rd_data !== 11'd0) begin bad++; $display("FAIL rd_row13 got=%h exp=0", rd_data); end
  endtask

  initial begin
    SIM_RST = 1'b1;
    rlyb    = '0;
    rywd    = '0;
    rd_row  = '0;
    wait_cyc(1);
    test_reset;
    test_single_word;
    test_glitch;
    test_bad_rows;
    test_back_to_back;
    test_reset_mid_settle;
    test_row_zero;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
